// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch front end: debounce state encoding
// and button channel indices.
package stopwatch_pkg;

  localparam logic [1:0] DB_RELEASED     = 2'd0;
  localparam logic [1:0] DB_PRESS_PEND   = 2'd1;
  localparam logic [1:0] DB_PRESSED      = 2'd2;
  localparam logic [1:0] DB_RELEASE_PEND = 2'd3;

  typedef enum logic [1:0] {
    ST_RELEASED     = DB_RELEASED,
    ST_PRESS_PEND   = DB_PRESS_PEND,
    ST_PRESSED      = DB_PRESSED,
    ST_RELEASE_PEND = DB_RELEASE_PEND
  } db_state_e;

  localparam int BTN_START_STOP = 0;
  localparam int BTN_SET        = 1;
  localparam int BTN_CHANGE     = 2;

endpackage

// File: rtl/button_debounce.sv
// One button channel: two-flop synchroniser, counter debounce FSM,
// registered press/release pulses and optional hold-to-repeat ticks.
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk100_i,
  input  logic rst_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic syncMeta_q, syncPin_q;
  logic pressedS;

  db_state_e state_q, state_d;
  logic [DB_W-1:0] dbCnt_q, dbCnt_d;
  logic level_q, level_d;
  logic press_q, release_q;
  logic pressAcc, releaseAcc;

  // Synchroniser holds the raw pin level, so reset value 1 means released.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      syncMeta_q <= 1'b1;
      syncPin_q  <= 1'b1;
    end else begin
      syncMeta_q <= btn_n_i;
      syncPin_q  <= syncMeta_q;
    end
  end

  assign pressedS = ~syncPin_q;

  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RELEASED;
      dbCnt_q   <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dbCnt_q   <= dbCnt_d;
      level_q   <= level_d;
      press_q   <= pressAcc;
      release_q <= releaseAcc;
    end
  end

  always_comb begin
    state_d    = state_q;
    dbCnt_d    = dbCnt_q;
    level_d    = level_q;
    pressAcc   = 1'b0;
    releaseAcc = 1'b0;
    unique case (state_q)
      ST_RELEASED: begin
        if (pressedS) begin
          state_d = ST_PRESS_PEND;
          dbCnt_d = DB_ONE;
        end
      end
      ST_PRESS_PEND: begin
        if (!pressedS) begin
          state_d = ST_RELEASED;
          dbCnt_d = '0;
        end else if (dbCnt_q == DB_LAST) begin
          state_d  = ST_PRESSED;
          dbCnt_d  = '0;
          level_d  = 1'b1;
          pressAcc = 1'b1;
        end else begin
          dbCnt_d = dbCnt_q + DB_ONE;
        end
      end
      ST_PRESSED: begin
        if (!pressedS) begin
          state_d = ST_RELEASE_PEND;
          dbCnt_d = DB_ONE;
        end
      end
      ST_RELEASE_PEND: begin
        if (pressedS) begin
          state_d = ST_PRESSED;
          dbCnt_d = '0;
        end else if (dbCnt_q == DB_LAST) begin
          state_d    = ST_RELEASED;
          dbCnt_d    = '0;
          level_d    = 1'b0;
          releaseAcc = 1'b1;
        end else begin
          dbCnt_d = dbCnt_q + DB_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        dbCnt_d = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
      localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(REPEAT_DELAY - 1);
      localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);
      localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

      logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;
      logic repeat_q, repeat_d;
      logic holding;

      assign holding = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_PEND);

      // Reloading after each tick keeps the counter bounded without saturation;
      // the tick is suppressed on the edge that accepts the release.
      always_comb begin
        holdCnt_d = holdCnt_q;
        repeat_d  = 1'b0;
        if (pressAcc) begin
          holdCnt_d = '0;
        end else if (holding && !releaseAcc) begin
          if (holdCnt_q == HOLD_LAST) begin
            holdCnt_d = HOLD_RELOAD;
            repeat_d  = 1'b1;
          end else begin
            holdCnt_d = holdCnt_q + HOLD_ONE;
          end
        end
      end

      always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
          holdCnt_q <= '0;
          repeat_q  <= 1'b0;
        end else begin
          holdCnt_q <= holdCnt_d;
          repeat_q  <= repeat_d;
        end
      end

      assign repeat_o = repeat_q;
    end else begin : g_no_repeat
      assign repeat_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/button_conditioner.sv
// Conditions the active-low stopwatch buttons into a clean level plus
// single-cycle press, release and repeat events, one independent channel each.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int               N_BTN           = 3,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 50_000_000,
  parameter int               REPEAT_PERIOD   = 10_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(1 << BTN_CHANGE)
) (
  input  logic             clk100_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_n_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  output logic [N_BTN-1:0] btn_repeat_o
);

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .REPEAT_EN      (REPEAT_MASK[i])
      ) u_debounce (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .btn_n_i  (btn_n_i[i]),
        .level_o  (btn_level_o[i]),
        .press_o  (btn_press_o[i]),
        .release_o(btn_release_o[i]),
        .repeat_o (btn_repeat_o[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulse
// events with their cycle, a negedge monitor pops and compares them.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = 2 + DEB;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b0;
  logic [2:0] btnN   = 3'b000;
  logic [2:0] level, press, rel, rpt;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] rpt;
    string      name;
  } expEvent_t;

  expEvent_t expQ[$];
  expEvent_t monEvt;
  int cycleCount = 0;
  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_BTN          (3),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .REPEAT_MASK    (3'b100)
  ) dut (
    .clk100_i     (clk100),
    .rst_i        (rst),
    .btn_n_i      (btnN),
    .btn_level_o  (level),
    .btn_press_o  (press),
    .btn_release_o(rel),
    .btn_repeat_o (rpt)
  );

  // 50 MHz clock
  always #10 clk100 = ~clk100;

  always @(posedge clk100) cycleCount <= cycleCount + 1;

  // Monitor: any pulse must match the oldest expected event, in the right cycle.
  always @(negedge clk100) begin
    while (expQ.size() > 0 && expQ[0].cyc < cycleCount) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no pulse seen, expected at cycle %0d (now %0d)",
               expQ[0].name, expQ[0].cyc, cycleCount);
      void'(expQ.pop_front());
    end
    if ((press | rel | rpt) !== 3'b000) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected: cycle %0d got press=%b release=%b repeat=%b, required none",
                 cycleCount, press, rel, rpt);
      end else begin
        monEvt = expQ.pop_front();
        if (monEvt.cyc != cycleCount || press !== monEvt.press ||
            rel !== monEvt.rel || rpt !== monEvt.rpt) begin
          errors++;
          $display("[TB] FAIL %s: got cycle %0d press=%b release=%b repeat=%b, required cycle %0d press=%b release=%b repeat=%b",
                   monEvt.name, cycleCount, press, rel, rpt,
                   monEvt.cyc, monEvt.press, monEvt.rel, monEvt.rpt);
        end
      end
    end
  end

  task automatic pushEvent(input int cyc, input logic [2:0] p, input logic [2:0] r,
                           input logic [2:0] t, input string name);
    expEvent_t e;
    e.cyc = cyc; e.press = p; e.rel = r; e.rpt = t; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic rstVal, input logic [2:0] pins);
    @(negedge clk100);
    #1;
    rst  = rstVal;
    btnN = pins;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk100);
  endtask

  task automatic checkOutput(input string name, input logic [2:0] expLevel,
                             input logic [2:0] expPress, input logic [2:0] expRel,
                             input logic [2:0] expRpt);
    checks++;
    if ({level, press, rel, rpt} !== {expLevel, expPress, expRel, expRpt}) begin
      errors++;
      $display("[TB] FAIL %s: got level=%b press=%b release=%b repeat=%b, required level=%b press=%b release=%b repeat=%b",
               name, level, press, rel, rpt, expLevel, expPress, expRel, expRpt);
    end
  endtask

  initial begin
    int base;
    #1 rst = 1'b1;

    // Reset with all buttons held down
    waitCycles(5);
    checkOutput("reset_outputs", 3'b000, 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b000);
    base = cycleCount;
    pushEvent(base + LAT, 3'b111, 3'b000, 3'b000, "reset_held_press");
    waitCycles(LAT + 1);
    checkOutput("reset_held_level", 3'b111, 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b111);
    base = cycleCount;
    pushEvent(base + LAT, 3'b000, 3'b111, 3'b000, "reset_held_release");
    waitCycles(LAT + 2);
    checkOutput("idle_after_release", 3'b000, 3'b000, 3'b000, 3'b000);

    // Clean press on channel 0
    applyStimulus(1'b0, 3'b110);
    base = cycleCount;
    pushEvent(base + LAT, 3'b001, 3'b000, 3'b000, "clean_press");
    waitCycles(12);
    checkOutput("clean_level", 3'b001, 3'b000, 3'b000, 3'b000);
    waitCycles(17);
    applyStimulus(1'b0, 3'b111);
    base = cycleCount;
    pushEvent(base + LAT, 3'b000, 3'b001, 3'b000, "clean_release");
    waitCycles(LAT + 2);
    checkOutput("clean_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // Bouncing channel 1, then settles pressed
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, (k % 2 == 0) ? 3'b101 : 3'b111);
      waitCycles(1);
    end
    checkOutput("bounce_no_level", 3'b000, 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b101);
    base = cycleCount;
    pushEvent(base + LAT, 3'b010, 3'b000, 3'b000, "bounce_press");
    waitCycles(LAT + 3);
    checkOutput("bounce_level", 3'b010, 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b111);
    base = cycleCount;
    pushEvent(base + LAT, 3'b000, 3'b010, 3'b000, "bounce_release");
    waitCycles(LAT + 2);

    // Hold-to-repeat on channel 2
    applyStimulus(1'b0, 3'b011);
    base = cycleCount;
    pushEvent(base + LAT, 3'b100, 3'b000, 3'b000, "repeat_press");
    for (int k = 0; k < 5; k++)
      pushEvent(base + LAT + RD + RP * k, 3'b000, 3'b000, 3'b100, $sformatf("repeat_tick%0d", k));
    waitCycles(59);
    applyStimulus(1'b0, 3'b111);
    base = cycleCount;
    pushEvent(base + LAT, 3'b000, 3'b100, 3'b000, "repeat_release");
    waitCycles(30);
    checkOutput("repeat_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // Reset in the middle of a channel-2 hold
    applyStimulus(1'b0, 3'b011);
    base = cycleCount;
    pushEvent(base + LAT, 3'b100, 3'b000, 3'b000, "prereset_press");
    waitCycles(13);
    checkOutput("prereset_level", 3'b100, 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b1, 3'b011);
    #1;
    checkOutput("midhold_reset", 3'b000, 3'b000, 3'b000, 3'b000);
    waitCycles(1);
    applyStimulus(1'b0, 3'b011);
    base = cycleCount;
    pushEvent(base + LAT, 3'b100, 3'b000, 3'b000, "postreset_press");
    waitCycles(9);
    applyStimulus(1'b0, 3'b111);
    base = cycleCount;
    pushEvent(base + LAT, 3'b000, 3'b100, 3'b000, "postreset_release");
    waitCycles(LAT + 2);

    // All three pressed together
    applyStimulus(1'b0, 3'b000);
    base = cycleCount;
    pushEvent(base + LAT, 3'b111, 3'b000, 3'b000, "simul_press");
    waitCycles(9);
    checkOutput("simul_level", 3'b111, 3'b000, 3'b000, 3'b000);
    applyStimulus(1'b0, 3'b111);
    base = cycleCount;
    pushEvent(base + LAT, 3'b000, 3'b111, 3'b000, "simul_release");
    waitCycles(LAT + 4);

    waitCycles(5);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events: got %0d left in queue, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
